// File: rtl/sync_fp_sqrt_iter.sv
// Clocked floating-point square root with a radix-2 restoring digit recurrence.
// Special operands bypass the recurrence; results are rounded to nearest-even.
module sync_fp_sqrt_iter #(
    parameter int EW     = 8,
    parameter int FW     = 23,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+FW:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+FW:0]   out_data,
    output logic             out_invalid,
    output logic             out_inexact,
    output logic             busy
);
    localparam int DW = EW + FW + 1;
    localparam int N  = (FW + 2) / UNROLL;
    localparam int RW = FW + 5;
    localparam int AW = 2 * FW + 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [EW:0]   BIAS = {2'b00, {(EW-1){1'b1}}};
    localparam logic [DW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

    if ((FW + 2) % UNROLL != 0) begin : gBadUnroll
        $error("sync_fp_sqrt_iter: UNROLL must divide FW+2");
    end

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    state_t state, stateNext;

    logic [AW-1:0] radReg, radStep;
    logic [RW-1:0] remReg, remStep, remShift, trial;
    logic [FW+1:0] qReg, qStep;
    logic [CW-1:0] cnt;
    logic [EW-1:0] reReg;

    logic          accept;
    logic          inSign;
    logic [EW-1:0] inExp;
    logic [FW-1:0] inFrac;
    logic          isZero, isNan, special;
    logic [DW-1:0] specData;
    logic          specInvalid;
    logic [EW:0]   eUnb, eHalf;
    logic [EW-1:0] reNorm;
    logic [FW+1:0] xMant;

    logic          roundBit, sticky;
    logic [FW:0]   mantSum;
    logic [EW-1:0] reOut;

    assign in_ready = arst && (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    assign {inSign, inExp, inFrac} = in_data;

    // Operand classification; zero/denormal wins over sign so sqrt(-0) = -0.
    always_comb begin
        isZero      = (inExp == '0);
        isNan       = (inExp == EMAX) && (inFrac != '0);
        special     = isZero || (inExp == EMAX) || inSign;
        specData    = in_data;
        specInvalid = 1'b0;
        if (isZero) begin
            specData = {inSign, {(EW+FW){1'b0}}};
        end else if (isNan) begin
            specData    = QNAN;
            specInvalid = !inFrac[FW-1];
        end else if (inSign) begin
            specData    = QNAN;
            specInvalid = 1'b1;
        end
    end

    // Odd exponents fold one factor of two into the mantissa so the halving is exact.
    always_comb begin
        eUnb   = {1'b0, inExp} - BIAS;
        eHalf  = {eUnb[EW], eUnb[EW:1]};
        reNorm = EW'(eHalf + BIAS);
        xMant  = eUnb[0] ? {1'b1, inFrac, 1'b0} : {2'b01, inFrac};
    end

    always_comb begin
        radStep  = radReg;
        remStep  = remReg;
        qStep    = qReg;
        remShift = '0;
        trial    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            remShift = {remStep[RW-3:0], radStep[AW-1 -: 2]};
            trial    = {1'b0, qStep, 2'b01};
            radStep  = {radStep[AW-3:0], 2'b00};
            if (remShift >= trial) begin
                remStep = remShift - trial;
                qStep   = {qStep[FW:0], 1'b1};
            end else begin
                remStep = remShift;
                qStep   = {qStep[FW:0], 1'b0};
            end
        end
    end

    // Q carries one guard bit below the fraction; the remainder acts as sticky.
    always_comb begin
        roundBit = qReg[0];
        sticky   = |remReg;
        mantSum  = {1'b0, qReg[FW:1]} + (FW+1)'(roundBit && (sticky || qReg[1]));
        reOut    = reReg + EW'(mantSum[FW]);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = special ? DONE : CALC;
            CALC:    if (cnt == LAST) stateNext = ROUND;
            ROUND:   stateNext = DONE;
            DONE:    if (out_valid && out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            state       <= IDLE;
            radReg      <= '0;
            remReg      <= '0;
            qReg        <= '0;
            cnt         <= '0;
            reReg       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (accept) begin
                    if (special) begin
                        out_data    <= specData;
                        out_invalid <= specInvalid;
                        out_inexact <= 1'b0;
                    end else begin
                        radReg <= {xMant, {(FW+2){1'b0}}};
                        remReg <= '0;
                        qReg   <= '0;
                        cnt    <= '0;
                        reReg  <= reNorm;
                    end
                end
                CALC: begin
                    radReg <= radStep;
                    remReg <= remStep;
                    qReg   <= qStep;
                    cnt    <= cnt + 1'b1;
                end
                ROUND: begin
                    out_data    <= {1'b0, reOut, mantSum[FW-1:0]};
                    out_invalid <= 1'b0;
                    out_inexact <= roundBit || sticky;
                end
                DONE: begin
                    // Result registers settle on DONE entry; valid follows one edge later.
                    if (!out_valid)
                        out_valid <= 1'b1;
                    else if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_fp_sqrt_iter.sv
// Bench for sync_fp_sqrt_iter: FP32 vectors, handshake corners, FP16 unroll sweep.
module tb_sync_fp_sqrt_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst, inValid, inReady, outValid, outReady, outInvalid, outInexact, busy;
    logic [31:0] inData, outData;

    sync_fp_sqrt_iter #(.EW(8), .FW(23), .UNROLL(1)) dut (
        .clk(clk), .arst(arst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .out_invalid(outInvalid), .out_inexact(outInexact), .busy(busy)
    );

    logic        hInValid, hOutReady;
    logic [15:0] hInData;
    logic [4:0]  hInReady, hOutValid, hInv, hInx, hBusy;
    logic [15:0] hOutData [5];

    for (genvar g = 0; g < 5; g++) begin : gHalf
        sync_fp_sqrt_iter #(.EW(5), .FW(10), .UNROLL((g == 4) ? 6 : g + 1)) dutH (
            .clk(clk), .arst(arst), .in_valid(hInValid), .in_ready(hInReady[g]), .in_data(hInData),
            .out_valid(hOutValid[g]), .out_ready(hOutReady), .out_data(hOutData[g]),
            .out_invalid(hInv[g]), .out_inexact(hInx[g]), .busy(hBusy[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: integer square root of the scaled mantissa, then nearest rounding.
    function automatic void refSqrt(input int ew, input int fw, input longint a,
                                    output longint r, output bit inv, output bit inx);
        longint emax, bias, sgn, ex, fr, e, m, t, s, lo, hi, mid, re;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        sgn  = (a >> (ew + fw)) & 1;
        ex   = (a >> fw) & emax;
        fr   = a & ((longint'(1) << fw) - 1);
        inv  = 0;
        inx  = 0;
        r    = 0;
        if (ex == 0) begin
            r = sgn << (ew + fw);
        end else if (ex == emax && fr != 0) begin
            r   = (emax << fw) | (longint'(1) << (fw - 1));
            inv = ((fr >> (fw - 1)) & 1) == 0;
        end else if (sgn != 0) begin
            r   = (emax << fw) | (longint'(1) << (fw - 1));
            inv = 1;
        end else if (ex == emax) begin
            r = a;
        end else begin
            e = ex - bias;
            m = (longint'(1) << fw) | fr;
            if ((e & 1) != 0) begin
                m = m << 1;
                e = e - 1;
            end
            t  = m << fw;
            lo = 0;
            hi = longint'(1) << (fw + 1);
            while (lo < hi) begin
                mid = (lo + hi + 1) / 2;
                if (mid * mid <= t) lo = mid;
                else hi = mid - 1;
            end
            s   = lo;
            inx = (s * s != t);
            if (t - s * s > s) s++;
            re = e / 2 + bias;
            if (s >= (longint'(1) << (fw + 1))) begin
                s = s >> 1;
                re++;
            end
            r = (re << fw) | (s & ((longint'(1) << fw) - 1));
        end
    endfunction

    task automatic run32(input logic [31:0] a, output logic [31:0] d,
                         output logic inv, output logic inx, output int lat);
        int w = 0;
        while (!inReady && w < 100) begin @(negedge clk); w++; end
        inValid = 1'b1;
        inData  = a;
        @(negedge clk);
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 200) begin @(negedge clk); lat++; end
        d   = outData;
        inv = outInvalid;
        inx = outInexact;
        @(negedge clk);
    endtask

    task automatic runH(input logic [15:0] a, input bit chkLat);
        int     w = 0;
        int     cyc = 0;
        int     lat [5];
        longint r;
        bit     inv, inx;
        while (hInReady != 5'h1f && w < 100) begin @(negedge clk); w++; end
        hInValid = 1'b1;
        hInData  = a;
        @(negedge clk);
        hInValid = 1'b0;
        for (int i = 0; i < 5; i++) lat[i] = -1;
        while (hOutValid != 5'h1f && cyc < 100) begin
            for (int i = 0; i < 5; i++) if (hOutValid[i] && lat[i] < 0) lat[i] = cyc;
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) if (hOutValid[i] && lat[i] < 0) lat[i] = cyc;
        refSqrt(5, 10, longint'(a), r, inv, inx);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("h%0d data %h", i, a), 64'(hOutData[i]), 64'(r));
            chk($sformatf("h%0d invalid %h", i, a), 64'(hInv[i]), 64'(inv));
            chk($sformatf("h%0d inexact %h", i, a), 64'(hInx[i]), 64'(inx));
            if (chkLat)
                chk($sformatf("h%0d latency", i), 64'(lat[i]), 64'(12 / ((i == 4) ? 6 : i + 1) + 2));
        end
        hOutReady = 1'b1;
        @(negedge clk);
        hOutReady = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        bit          inv;
        bit          inx;
        int          lat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] d, a;
        logic        inv, inx;
        int          lat, w, seen;
        longint      r;
        bit          rInv, rInx;

        tbl[0]  = '{32'h40800000, 32'h40000000, 0, 0, 27};
        tbl[1]  = '{32'h40000000, 32'h3FB504F3, 0, 1, 27};
        tbl[2]  = '{32'h3E800000, 32'h3F000000, 0, 0, 27};
        tbl[3]  = '{32'h41100000, 32'h40400000, 0, 0, 27};
        tbl[4]  = '{32'h3F800000, 32'h3F800000, 0, 0, 27};
        tbl[5]  = '{32'h00800000, 32'h20000000, 0, 0, 27};
        tbl[6]  = '{32'hBF800000, 32'h7FC00000, 1, 0, 1};
        tbl[7]  = '{32'h80000000, 32'h80000000, 0, 0, 1};
        tbl[8]  = '{32'h00000001, 32'h00000000, 0, 0, 1};
        tbl[9]  = '{32'h80000001, 32'h80000000, 0, 0, 1};
        tbl[10] = '{32'h7F800000, 32'h7F800000, 0, 0, 1};
        tbl[11] = '{32'h7FC00001, 32'h7FC00000, 0, 0, 1};
        tbl[12] = '{32'h7F800001, 32'h7FC00000, 1, 0, 1};
        tbl[13] = '{32'hFF800000, 32'h7FC00000, 1, 0, 1};
        tbl[14] = '{32'hFFC00000, 32'h7FC00000, 0, 0, 1};

        arst = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1;
        hInValid = 1'b0; hInData = '0; hOutReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(outValid), 0);
        chk("reset in_ready", 64'(inReady), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset out_data", 64'(outData), 0);
        chk("reset flags", 64'({outInvalid, outInexact}), 0);
        arst = 1'b1;
        @(negedge clk);
        chk("idle in_ready", 64'(inReady), 1);

        for (int i = 0; i < 15; i++) begin
            run32(tbl[i].a, d, inv, inx, lat);
            chk($sformatf("tbl%0d data", i), 64'(d), 64'(tbl[i].r));
            chk($sformatf("tbl%0d invalid", i), 64'(inv), 64'(tbl[i].inv));
            chk($sformatf("tbl%0d inexact", i), 64'(inx), 64'(tbl[i].inx));
            chk($sformatf("tbl%0d latency", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int i = 0; i < 40; i++) begin
            if (i < 30) a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            else        a = $urandom;
            refSqrt(8, 23, longint'(a), r, rInv, rInx);
            run32(a, d, inv, inx, lat);
            chk($sformatf("rnd data %h", a), 64'(d), 64'(r));
            chk($sformatf("rnd invalid %h", a), 64'(inv), 64'(rInv));
            chk($sformatf("rnd inexact %h", a), 64'(inx), 64'(rInx));
        end

        // Backpressure; in_valid stays high with other data while the unit is busy.
        outReady = 1'b0;
        inValid  = 1'b1;
        inData   = 32'h41100000;
        @(negedge clk);
        inData = 32'h3F800000;
        w = 0;
        while (!outValid && w < 200) begin @(negedge clk); w++; end
        chk("bp latency", 64'(w), 27);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d data", i), 64'(outData), 64'h40400000);
            chk($sformatf("bp%0d valid/ready/busy", i), 64'({outValid, inReady, busy}), 64'(3'b101));
            @(negedge clk);
        end
        outReady = 1'b1;
        inValid  = 1'b0;
        @(negedge clk);
        chk("bp release valid/ready/busy", 64'({outValid, inReady, busy}), 64'(3'b010));

        // Reset in the middle of the recurrence.
        inValid = 1'b1;
        inData  = 32'h40800000;
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midcalc busy", 64'(busy), 1);
        arst = 1'b0;
        #1;
        chk("rst in_ready", 64'(inReady), 0);
        @(negedge clk);
        chk("rst valid/busy", 64'({outValid, busy}), 0);
        chk("rst out_data", 64'(outData), 0);
        arst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (outValid) seen = 1;
        end
        chk("no stale result", 64'(seen), 0);
        run32(32'h41100000, d, inv, inx, lat);
        chk("post-reset data", 64'(d), 64'h40400000);
        chk("post-reset latency", 64'(lat), 27);

        runH(16'h4400, 1'b1);
        runH(16'hFC00, 1'b0);
        for (int i = 0; i < 25; i++)
            runH({1'b0, 5'($urandom_range(1, 30)), 10'($urandom)}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
